pulse_interval_meter: RTL and testbench



---
 rtl/pulse_interval_meter.sv | 180 ++++++++++++++++++
 tb/tb_pulse_interval_meter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_interval_meter.sv
// pulse_interval_meter: per-channel sync, qualify, edge detect and interval timing
// with round-robin streaming. Glitch filter enabled by `define PULSE_GLITCH_FILTER_EN.
module pulse_interval_meter #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_STABLE  = 4,
    parameter int CH_W        = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] pulse_in,
    output logic [CHANNELS-1:0] pulse_detected,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    output logic [CNT_W-1:0]    out_interval,
    output logic                out_sat,
    output logic [CHANNELS-1:0] overrun,
    input  logic                overrun_clr
);

    if (CHANNELS < 2 || SYNC_STAGES < 2 || MIN_STABLE < 1) begin : g_bad_param
        $error("pulse_interval_meter: illegal parameter value");
    end

    logic [CHANNELS-1:0] hold_valid;
    logic [CNT_W-1:0]    hold_int [CHANNELS];
    logic [CHANNELS-1:0] hold_sat;
    logic [CHANNELS-1:0] grant;
    logic [CHANNELS-1:0] ovr_evt;
    logic [CH_W-1:0]     rr_ptr;
    logic [CH_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic                load;

    function automatic logic [CH_W-1:0] rr_idx(
        input logic [CH_W-1:0] p,
        input int              k
    );
        int s;
        s = (int'(p) + k) % CHANNELS;
        return CH_W'(s);
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s_lvl;
        logic                   filt_q;
        logic                   filt_d;
        logic                   det_q;
        logic [CNT_W-1:0]       tmr_q;
        logic                   tmr_max;
        logic                   armed_q;
        logic                   cap;
        logic                   hv_q;
        logic [CNT_W-1:0]       hint_q;
        logic                   hsat_q;

        assign s_lvl = sync_q[SYNC_STAGES-1];

        // bring the asynchronous pin into the clock domain
        always_ff @(posedge clk) begin
            if (rst) sync_q <= '0;
            else     sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in[i]};
        end

`ifdef PULSE_GLITCH_FILTER_EN
        localparam int FW = $clog2(MIN_STABLE + 1);
        logic [FW-1:0] stab_q;
        logic          stab_done;

        assign stab_done = (stab_q == FW'(MIN_STABLE - 1));
        assign filt_d    = (s_lvl != filt_q && stab_done) ? s_lvl : filt_q;

        // count how long the new level has persisted; any return restarts it
        always_ff @(posedge clk) begin
            if (rst)                             stab_q <= '0;
            else if (s_lvl == filt_q || stab_done) stab_q <= '0;
            else                                 stab_q <= stab_q + FW'(1);
        end
`else
        assign filt_d = s_lvl;
`endif

        // qualified level and its registered rising-edge strobe
        always_ff @(posedge clk) begin
            if (rst) begin
                filt_q <= 1'b0;
                det_q  <= 1'b0;
            end else begin
                filt_q <= filt_d;
                det_q  <= filt_d & ~filt_q;
            end
        end

        assign tmr_max = &tmr_q;
        assign cap     = det_q & armed_q;

        // saturating timer restarted at 1 by each strobe so spacing N reads N
        always_ff @(posedge clk) begin
            if (rst) begin
                tmr_q   <= '0;
                armed_q <= 1'b0;
            end else if (det_q) begin
                tmr_q   <= CNT_W'(1);
                armed_q <= 1'b1;
            end else if (!tmr_max) begin
                tmr_q   <= tmr_q + CNT_W'(1);
            end
        end

        // one-deep hold; a capture always wins over a same-cycle drain
        always_ff @(posedge clk) begin
            if (rst) begin
                hv_q   <= 1'b0;
                hint_q <= '0;
                hsat_q <= 1'b0;
            end else if (cap) begin
                hv_q   <= 1'b1;
                hint_q <= tmr_q;
                hsat_q <= tmr_max;
            end else if (grant[i]) begin
                hv_q   <= 1'b0;
            end
        end

        assign ovr_evt[i]        = cap & hv_q & ~grant[i];
        assign hold_valid[i]     = hv_q;
        assign hold_int[i]       = hint_q;
        assign hold_sat[i]       = hsat_q;
        assign pulse_detected[i] = det_q;
    end

    assign load = ~out_valid | out_ready;

    // round-robin search beginning just after the last granted channel
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            if (!gnt_any && hold_valid[rr_idx(rr_ptr, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx(rr_ptr, k);
            end
        end
    end

    // one-hot drain of the hold that moves into the output register
    always_comb begin
        grant = '0;
        if (load && gnt_any) grant[gnt_idx] = 1'b1;
    end

    // output register; frozen while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_ch       <= '0;
            out_interval <= '0;
            out_sat      <= 1'b0;
            rr_ptr       <= CH_W'(CHANNELS - 1);
        end else if (load) begin
            out_valid <= gnt_any;
            if (gnt_any) begin
                out_ch       <= gnt_idx;
                out_interval <= hold_int[gnt_idx];
                out_sat      <= hold_sat[gnt_idx];
                rr_ptr       <= gnt_idx;
            end
        end
    end

    // sticky lost-interval flags; a fresh loss outranks the clear
    always_ff @(posedge clk) begin
        if (rst) overrun <= '0;
        else     overrun <= (overrun & ~{CHANNELS{overrun_clr}}) | ovr_evt;
    end

endmodule

// File: tb/tb_pulse_interval_meter.sv
// tb_pulse_interval_meter: directed and random checks of pulse_interval_meter
// against an edge-time / interval-queue reference model.
module tb_pulse_interval_meter;
    localparam int CH  = 4;
    localparam int W   = 24;
    localparam int SS  = 2;
    localparam int MSP = 4;
`ifdef PULSE_GLITCH_FILTER_EN
    localparam int MS = MSP;
`else
    localparam int MS = 1;
`endif
    localparam longint MAXV = (longint'(1) << W) - 1;

    typedef struct {
        int     ch;
        longint iv;
        bit     sat;
    } word_t;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic [CH-1:0] pulse_in    = '0;
    logic          out_ready   = 1'b0;
    logic          overrun_clr = 1'b0;
    logic [CH-1:0] pd, ovr, pd8, ovr8;
    logic          ov, osat, ov8, osat8;
    logic [1:0]    och, och8;
    logic [W-1:0]  oint;
    logic [7:0]    oint8;

    pulse_interval_meter #(
        .CHANNELS(CH), .CNT_W(W), .SYNC_STAGES(SS), .MIN_STABLE(MSP)
    ) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in),
        .pulse_detected(pd), .out_valid(ov), .out_ready(out_ready),
        .out_ch(och), .out_interval(oint), .out_sat(osat),
        .overrun(ovr), .overrun_clr(overrun_clr)
    );

    pulse_interval_meter #(
        .CHANNELS(CH), .CNT_W(8), .SYNC_STAGES(SS), .MIN_STABLE(MSP)
    ) dut8 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in),
        .pulse_detected(pd8), .out_valid(ov8), .out_ready(out_ready),
        .out_ch(och8), .out_interval(oint8), .out_sat(osat8),
        .overrun(ovr8), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    word_t         pend[$];
    logic [CH-1:0] h [8];
    logic [CH-1:0] mf;
    int            run [CH];
    bit            armed [CH];
    longint        last [CH];
    longint        cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_words = 0;
    int            n8 = 0;
    int            det_cnt [CH];
    int            lw_ch, l8_ch;
    longint        lw_iv, l8_iv;
    bit            lw_sat, l8_sat;
    int            xl_ch[$];
    longint        xl_cyc[$];
    bit            chk_ovr = 1'b1;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) h[k] = '0;
        mf = '0;
        for (int c = 0; c < CH; c++) begin
            run[c]   = 0;
            armed[c] = 1'b0;
            last[c]  = 0;
        end
        pend.delete();
    endtask

    task automatic detect(int c);
        word_t  w;
        longint d;
        if (armed[c]) begin
            d     = cyc - last[c];
            w.ch  = c;
            w.sat = (d >= MAXV);
            w.iv  = w.sat ? MAXV : d;
            pend.push_back(w);
        end
        armed[c] = 1'b1;
        last[c]  = cyc;
    endtask

    task automatic take_word(int c, longint iv, bit s);
        int idx;
        idx = -1;
        n_words++;
        lw_ch  = c;
        lw_iv  = iv;
        lw_sat = s;
        xl_ch.push_back(c);
        xl_cyc.push_back(cyc);
        for (int k = 0; k < pend.size(); k++)
            if (idx < 0 && pend[k].ch == c) idx = k;
        n_cmp++;
        assert (idx >= 0) else begin
            n_bad++;
            $error("FAIL word_expected: observed word on ch %0d iv %0d, required none", c, iv);
        end
        if (idx >= 0) begin
            check("word_interval", iv, pend[idx].iv);
            check("word_sat", s, pend[idx].sat);
            pend.delete(idx);
        end
    endtask

    task automatic drop(int c, longint iv);
        int idx;
        idx = -1;
        for (int k = 0; k < pend.size(); k++)
            if (idx < 0 && pend[k].ch == c && pend[k].iv == iv) idx = k;
        check("lost_word_present", (idx >= 0), 1);
        if (idx >= 0) pend.delete(idx);
    endtask

    task automatic tick();
        bit            x, x8;
        int            wc, w8c;
        longint        wi, w8i;
        bit            ws, w8s;
        logic [CH-1:0] ed;
        x   = ov && out_ready && !rst;
        wc  = int'(och);
        wi  = longint'(oint);
        ws  = osat;
        x8  = ov8 && out_ready && !rst;
        w8c = int'(och8);
        w8i = longint'(oint8);
        w8s = osat8;
        @(posedge clk);
        cyc++;
        for (int k = 7; k > 0; k--) h[k] = h[k-1];
        h[0] = pulse_in;
        ed   = '0;
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (h[SS][c] != mf[c]) begin
                    run[c]++;
                    if (run[c] >= MS) begin
                        mf[c]  = h[SS][c];
                        run[c] = 0;
                        if (mf[c]) begin
                            ed[c] = 1'b1;
                            detect(c);
                        end
                    end
                end else begin
                    run[c] = 0;
                end
            end
            if (x) take_word(wc, wi, ws);
        end
        #1;
        check("pulse_detected", pd, ed);
        for (int c = 0; c < CH; c++) if (pd[c]) det_cnt[c]++;
        if (x8) begin
            n8++;
            l8_ch  = w8c;
            l8_iv  = w8i;
            l8_sat = w8s;
        end
        if (chk_ovr) check("overrun_idle", ovr, 0);
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic pulse(int c, int hi, int lo);
        pulse_in[c] = 1'b1;
        ticks(hi);
        pulse_in[c] = 1'b0;
        ticks(lo);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_pd"}, pd, 0);
        check({tag, "_valid"}, ov, 0);
        check({tag, "_ch"}, och, 0);
        check({tag, "_interval"}, oint, 0);
        check({tag, "_sat"}, osat, 0);
        check({tag, "_overrun"}, ovr, 0);
    endtask

    initial begin
        int n0, d0, x0, lowrun;
        int left [CH];
        model_reset();
        for (int c = 0; c < CH; c++) det_cnt[c] = 0;

        // reset state
        ticks(3);
        check_zero("reset");
        rst = 1'b0;

        // latency and arming: three ch0 edges 100 cycles apart
        out_ready = 1'b1;
        n0 = n_words;
        d0 = det_cnt[0];
        repeat (3) pulse(0, 5, 95);
        ticks(10);
        check("arm_words", n_words - n0, 2);
        check("arm_strobes", det_cnt[0] - d0, 3);
        check("arm_ch", lw_ch, 0);
        check("arm_iv", lw_iv, 100);
        check("arm_sat", lw_sat, 0);

`ifdef PULSE_GLITCH_FILTER_EN
        // glitch filter: 3-cycle pulse rejected, 4-cycle pulse accepted
        d0 = det_cnt[1];
        pulse(1, 3, 12);
        check("glitch_short", det_cnt[1] - d0, 0);
        pulse(1, 4, 12);
        check("glitch_long", det_cnt[1] - d0, 1);
`else
        // unfiltered: a single-cycle pulse is already a valid edge
        d0 = det_cnt[1];
        pulse(1, 1, 12);
        check("single_cycle", det_cnt[1] - d0, 1);
`endif

        // saturation on the 8-bit instance, edges 300 apart
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n0 = n8;
        pulse(3, 5, 295);
        pulse(3, 5, 20);
        check("sat_words", n8 - n0, 1);
        check("sat_ch", l8_ch, 3);
        check("sat_iv", l8_iv, 255);
        check("sat_flag", l8_sat, 1);

        // arbitration under backpressure, all channels interval 50
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_in = '1;
        ticks(5);
        pulse_in = '0;
        ticks(45);
        pulse_in  = '1;
        out_ready = 1'b0;
        ticks(5);
        pulse_in = '0;
        for (int r = 0; r < 3; r++) begin
            check("stall_valid", ov, 1);
            check("stall_ch", och, 0);
            check("stall_iv", oint, 50);
            check("stall_sat", osat, 0);
            ticks(5);
        end
        x0 = xl_ch.size();
        out_ready = 1'b1;
        ticks(6);
        check("arb_count", xl_ch.size() - x0, 4);
        if (xl_ch.size() - x0 >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check("arb_order", xl_ch[x0 + k], k);
                check("arb_back2back", xl_cyc[x0 + k] - xl_cyc[x0], k);
            end
        end

        // overrun: ch2 intervals 10, 20, 30 with the consumer stalled
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        chk_ovr   = 1'b0;
        pulse(2, 5, 5);
        pulse(2, 5, 15);
        pulse(2, 5, 25);
        pulse(2, 5, 10);
        check("ovr_set", ovr, 4'b0100);
        drop(2, 20);
        out_ready = 1'b1;
        ticks(6);
        check("ovr_last_ch", lw_ch, 2);
        check("ovr_last_iv", lw_iv, 30);
        check("ovr_sticky", ovr, 4'b0100);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clear", ovr, 0);
        chk_ovr = 1'b1;

        // reset between two ch0 edges
        pulse(0, 5, 35);
        pulse(0, 5, 20);
        check("pre_rst_ch", lw_ch, 0);
        check("pre_rst_iv", lw_iv, 40);
        rst = 1'b1;
        tick();
        check_zero("mid_reset");
        rst = 1'b0;
        n0 = n_words;
        ticks(10);
        pulse(0, 5, 30);
        check("rearm_no_word", n_words - n0, 0);

        // random traffic on all channels with bursty backpressure
        lowrun = 0;
        for (int c = 0; c < CH; c++) left[c] = $urandom_range(5, 30);
        pulse_in = '0;
        repeat (3000) begin
            for (int c = 0; c < CH; c++) begin
                if (left[c] == 0) begin
                    pulse_in[c] = ~pulse_in[c];
                    left[c] = pulse_in[c] ? $urandom_range(1, 10)
                                          : $urandom_range(15, 60);
                end else begin
                    left[c]--;
                end
            end
            if (lowrun >= 2) out_ready = 1'b1;
            else             out_ready = ($urandom_range(0, 3) != 0);
            lowrun = out_ready ? 0 : lowrun + 1;
            tick();
        end
        pulse_in  = '0;
        out_ready = 1'b1;
        ticks(40);
        check("drain_empty", pend.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
